// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised, glitch-filtered clock; frame FSM with
// watchdog; optional E0/F0 prefix folding; first-word fall-through FIFO with fill level.
module ps2_rx_fifo #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned TIMEOUT    = 50000,
  parameter int unsigned DECODE     = 1,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  input  logic          rd_en,
  input  logic          err_clr,
  output logic [9:0]    data,
  output logic          ready,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          parity_err,
  output logic          frame_err
);

  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
  localparam int unsigned WCW = $clog2(TIMEOUT + 1);
  localparam logic [FCW-1:0] FiltMax = FCW'(FILTER_LEN - 1);
  localparam logic [WCW-1:0] WdMax   = WCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Synchronisers and filter
  logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic           filt_d, filt_q;
  logic [FCW-1:0] filt_cnt_d, filt_cnt_q;
  logic           sample;

  // Frame FSM
  state_e         state_d, state_q;
  logic [2:0]     bitcnt_d, bitcnt_q;
  logic [7:0]     shift_d, shift_q;
  logic           par_d, par_q;
  logic [WCW-1:0] wdog_d, wdog_q;
  logic           ext_d, ext_q, brk_d, brk_q;
  logic           push_d, push_q;
  logic [9:0]     push_data_d, push_data_q;
  logic           frame_set, parity_set;

  // FIFO
  logic [9:0]     mem_d [DEPTH];
  logic [9:0]     mem_q [DEPTH];
  logic [AW:0]    wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic           full, pop, wr, ovf_set;
  logic           overflow_d, overflow_q, parity_err_d, parity_err_q;
  logic           frame_err_d, frame_err_q;

  // Two-flop synchronisers, idle bus level is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Filtered clock follows the synchronised clock after FILTER_LEN stable cycles
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FiltMax) begin
        filt_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // Strobe coincides with the filtered clock falling
  assign sample = filt_q & ~filt_d;

  // Frame FSM, watchdog and prefix decoder next-state
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    frame_set   = 1'b0;
    parity_set  = 1'b0;
    wdog_d      = (state_q == StIdle || sample) ? '0 : wdog_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (sample) begin
          if (!dat_s2_q) begin
            state_d  = StData;
            bitcnt_d = 3'd0;
          end else begin
            frame_set = 1'b1;
          end
        end
      end
      StData: begin
        if (sample) begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (sample) begin
          par_d   = dat_s2_q;
          state_d = StStop;
        end
      end
      StStop: begin
        if (sample) begin
          state_d = StIdle;
          if (!dat_s2_q) begin
            frame_set = 1'b1;
          end else if (!(^{shift_q, par_q})) begin
            parity_set = 1'b1;
          end else if (DECODE != 0 && shift_q == 8'hE0) begin
            ext_d = 1'b1;
          end else if (DECODE != 0 && shift_q == 8'hF0) begin
            brk_d = 1'b1;
          end else begin
            push_d      = 1'b1;
            push_data_d = {ext_q, brk_q, shift_q};
            ext_d       = 1'b0;
            brk_d       = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Watchdog abort overrides any in-frame progress
    if (state_q != StIdle && !sample && wdog_q == WdMax) begin
      state_d   = StIdle;
      wdog_d    = '0;
      frame_set = 1'b1;
    end
  end

  // FIFO pointers, storage and sticky flags next-state
  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop      = rd_en & ready;
    wr       = push_q & (~full | pop);
    ovf_set  = push_q & full & ~pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data_q;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    // A new error in the clearing cycle survives the clear
    overflow_d   = (overflow_q & ~err_clr) | ovf_set;
    parity_err_d = (parity_err_q & ~err_clr) | parity_set;
    frame_err_d  = (frame_err_q & ~err_clr) | frame_set;
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q       <= 1'b1;
      filt_cnt_q   <= '0;
      state_q      <= StIdle;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      wdog_q       <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      filt_q       <= filt_d;
      filt_cnt_q   <= filt_cnt_d;
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      wdog_q       <= wdog_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign data       = mem_q[rd_ptr_q[AW-1:0]];
  assign ready      = (wr_ptr_q != rd_ptr_q);
  assign level      = wr_ptr_q - rd_ptr_q;
  assign overflow   = overflow_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: frames are driven on the PS/2 pins, the bench's
// decoder model queues expected words, reads pop and compare them.
module tb_ps2_rx_fifo;

  localparam int unsigned Depth   = 8;
  localparam int unsigned Timeout = 200;
  localparam int unsigned Half    = 10;

  logic       clk, rst, ps2_clk, ps2_data, rd_en, err_clr;
  logic [9:0] data;
  logic       ready, overflow, parity_err, frame_err;
  logic [3:0] level;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] sb[$];
  logic ext_m = 1'b0;
  logic brk_m = 1'b0;

  ps2_rx_fifo #(
    .DEPTH(Depth), .FILTER_LEN(4), .TIMEOUT(Timeout), .DECODE(1)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .err_clr(err_clr), .data(data), .ready(ready), .level(level), .overflow(overflow),
    .parity_err(parity_err), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "time limit");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    wait_cyc(Half);
    ps2_clk = 1'b0;
    wait_cyc(Half);
    ps2_clk = 1'b1;
  endtask

  // Drive nbits of a frame (11 = complete); model the decoder when the frame is good
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(bits[i]);
    @(negedge clk);
    ps2_data = 1'b1;
    wait_cyc(2 * Half);
    if (nbits == 11 && !bad_par && !bad_stop) begin
      if (b == 8'hE0) ext_m = 1'b1;
      else if (b == 8'hF0) brk_m = 1'b1;
      else begin
        if (sb.size() < Depth) sb.push_back({ext_m, brk_m, b});
        ext_m = 1'b0;
        brk_m = 1'b0;
      end
    end
  endtask

  task automatic do_read();
    logic [9:0] exp;
    @(negedge clk);
    if (sb.size() == 0) begin
      check_eq("sb_nonempty", 32'd0, 32'd1);
    end else begin
      exp = sb.pop_front();
      check_eq("ready_at_read", {31'd0, ready}, 32'd1);
      check_eq("data", {22'd0, data}, {22'd0, exp});
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, {31'd0, ready}, 32'd0);
    check_eq({tag, "_level"}, {28'd0, level}, 32'd0);
    check_eq({tag, "_data"}, {22'd0, data}, 32'd0);
    check_eq({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    check_eq({tag, "_perr"}, {31'd0, parity_err}, 32'd0);
    check_eq({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    wait_cyc(4);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_cyc(4);

    // Single plain frame
    send_frame(8'h1C, 0, 0, 11);
    check_eq("t1_level", {28'd0, level}, 32'd1);
    do_read();
    check_eq("t1_ready_after", {31'd0, ready}, 32'd0);
    check_eq("t1_level_after", {28'd0, level}, 32'd0);

    // Prefix folding
    send_frame(8'hF0, 0, 0, 11);
    check_eq("t2_prefix_noslot", {28'd0, level}, 32'd0);
    send_frame(8'h1C, 0, 0, 11);
    check_eq("t2_brk_level", {28'd0, level}, 32'd1);
    do_read();
    send_frame(8'hE0, 0, 0, 11);
    send_frame(8'hF0, 0, 0, 11);
    send_frame(8'h75, 0, 0, 11);
    check_eq("t2_ext_level", {28'd0, level}, 32'd1);
    do_read();

    // Parity and framing errors
    send_frame(8'h1C, 1, 0, 11);
    check_eq("t3_perr", {31'd0, parity_err}, 32'd1);
    check_eq("t3_perr_ferr", {31'd0, frame_err}, 32'd0);
    check_eq("t3_perr_level", {28'd0, level}, 32'd0);
    pulse_clr();
    check_eq("t3_perr_clr", {31'd0, parity_err}, 32'd0);
    send_frame(8'h33, 0, 1, 11);
    check_eq("t3_ferr", {31'd0, frame_err}, 32'd1);
    check_eq("t3_ferr_level", {28'd0, level}, 32'd0);
    pulse_clr();

    // Overflow: nine frames, only the first eight survive
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 0, 0, 11);
    check_eq("t4_level_full", {28'd0, level}, 32'd8);
    check_eq("t4_ovf", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 8; i++) do_read();
    check_eq("t4_level_drained", {28'd0, level}, 32'd0);
    pulse_clr();

    // Push coinciding with a pop while full
    for (int i = 0; i < 8; i++) send_frame(8'h40 + 8'(i), 0, 0, 11);
    check_eq("t4_refill", {28'd0, level}, 32'd8);
    fork
      send_frame(8'h48, 0, 0, 11);
      begin
        int k;
        k = 0;
        @(negedge clk);
        while (dut.push_q !== 1'b1 && k < 2000) begin
          @(negedge clk);
          k++;
        end
        check_eq("t4_push_seen", {31'd0, dut.push_q}, 32'd1);
        // rd_en held through the push edge
        check_eq("t4_sim_data", {22'd0, data}, {22'd0, sb.pop_front()});
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    check_eq("t4_sim_level", {28'd0, level}, 32'd8);
    check_eq("t4_sim_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 8; i++) do_read();

    // Watchdog abort after a partial frame
    send_frame(8'h55, 0, 0, 4);
    wait_cyc(Timeout + 50);
    check_eq("t5_timeout_ferr", {31'd0, frame_err}, 32'd1);
    pulse_clr();
    send_frame(8'h2A, 0, 0, 11);
    check_eq("t5_ferr_after", {31'd0, frame_err}, 32'd0);
    do_read();

    // One-cycle clock glitch must not produce a sample
    @(negedge clk);
    ps2_clk = 1'b0;
    @(negedge clk);
    ps2_clk = 1'b1;
    wait_cyc(20);
    check_eq("t6_glitch_ferr", {31'd0, frame_err}, 32'd0);
    check_eq("t6_glitch_level", {28'd0, level}, 32'd0);

    // Reset mid-frame, with a stored entry and a sticky flag present
    send_frame(8'h66, 0, 0, 11);
    send_frame(8'h1C, 1, 0, 11);
    send_frame(8'h77, 0, 0, 4);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    ext_m = 1'b0;
    brk_m = 1'b0;
    wait_cyc(2);
    check_reset_outputs("t6_midrst");
    rst = 1'b0;
    wait_cyc(4);
    send_frame(8'h1C, 0, 0, 11);
    check_eq("t6_post_level", {28'd0, level}, 32'd1);
    do_read();
    check_eq("t6_post_ferr", {31'd0, frame_err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
